uart_out_tx: RTL and testbench

- Downstream consumer of the CPU OUT port. Each CPU OUT instruction is one byte write into this block.
- Buffers bytes in a small FIFO and serialises them on a single UART 8N1 line, LSB first.
- Lets the CPU issue OUT back-to-back without stalling, up to FIFO_DEPTH bytes ahead of the line.
- The CPU top drives data_i from the ACC output bus and wen_i from the OUT control strobe.

---
 rtl/uart_out_tx_pkg.sv | 14 +
 rtl/uart_out_tx_sync_fifo.sv | 57 +++++
 rtl/uart_out_tx.sv | 137 +++++++++++++
 tb/tb_uart_out_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_out_tx_pkg.sv
// Shared types for the CPU OUT-port UART transmitter.
// Frame FSM state encoding and the data byte width.
package uart_out_tx_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_out_tx_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head.
// Ports: clk_i, rst_i, wen_i, ren_i, din_i / dout_o, full_o, empty_o, count_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wen_i,
  input  logic                       ren_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Accept/pop are gated by the registered flags, so the count
  // can never run past either end.
  assign w_push = wen_i && !full_o;
  assign w_pop  = ren_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout_o  = r_mem[r_rptr];
  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

endmodule

// File: rtl/uart_out_tx.sv
// CPU OUT-port sink: buffers bytes and sends them as UART 8N1, LSB first.
// Ports: clk_i, rst_i, data_i, wen_i / tx_o, busy_o, full_o, empty_o, count_o, overflow_o.
module uart_out_tx
  import uart_out_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    data_i,
  input  logic                          wen_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_e            r_state;
  state_e            w_next;
  logic [15:0]       r_baud;
  logic [15:0]       w_baud_d;
  logic [2:0]        r_idx;
  logic [2:0]        w_idx_d;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_d;
  logic              r_tx;
  logic              w_tx_d;
  logic              r_ovf;
  logic              w_pop;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_head;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wen_i   (wen_i),
    .ren_i   (w_pop),
    .din_i   (data_i),
    .dout_o  (w_head),
    .full_o  (full_o),
    .empty_o (empty_o),
    .count_o (count_o)
  );

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (!empty_o) w_next = ST_START;
      ST_START: if (w_bit_end) w_next = ST_DATA;
      ST_DATA:  if (w_bit_end && r_idx == 3'd7) w_next = ST_STOP;
      ST_STOP:  if (w_bit_end) w_next = empty_o ? ST_IDLE : ST_START;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Next values for the line/datapath registers; tx_o stays a pure
  // register output so the line never glitches from inputs.
  always_comb begin
    w_pop     = 1'b0;
    w_tx_d    = r_tx;
    w_shift_d = r_shift;
    w_idx_d   = r_idx;
    w_baud_d  = w_bit_end ? 16'd0 : r_baud + 16'd1;
    unique case (r_state)
      ST_IDLE: begin
        w_baud_d = 16'd0;
        w_tx_d   = 1'b1;
        if (!empty_o) begin
          w_pop     = 1'b1;
          w_shift_d = w_head;
          w_tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_tx_d  = r_shift[0];
          w_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_d = r_shift >> 1;
          w_idx_d   = r_idx + 3'd1;
          w_tx_d    = (r_idx == 3'd7) ? 1'b1 : r_shift[1];
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_tx_d = 1'b1;
          // Back-to-back frames: no idle gap between stop and start.
          if (!empty_o) begin
            w_pop     = 1'b1;
            w_shift_d = w_head;
            w_tx_d    = 1'b0;
          end
        end
      end
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx    <= 1'b1;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_tx    <= w_tx_d;
      r_baud  <= w_baud_d;
      r_idx   <= w_idx_d;
      r_shift <= w_shift_d;
      if (wen_i && full_o) r_ovf <= 1'b1;
    end
  end

  assign tx_o       = r_tx;
  assign busy_o     = (r_state != ST_IDLE);
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_uart_out_tx.sv
// Self-checking bench for uart_out_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Frame-schedule reference model compared against every output each cycle.
module tb_uart_out_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] data_i = '0;
  logic       wen_i = 1'b0;
  logic       tx_o;
  logic       busy_o;
  logic       full_o;
  logic       empty_o;
  logic [2:0] count_o;
  logic       overflow_o;

  uart_out_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .wen_i      (wen_i),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model: each accepted byte has an accept edge and a pop edge
  // (the edge its start bit begins).
  int         fa[$];
  int         fs[$];
  logic [7:0] fd[$];
  int         e = 0;
  int         last_s = 0;
  bit         have_last = 0;
  bit         m_ovf = 0;
  int         peak;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, e, got, exp);
    end
  endtask

  function automatic int occupancy(input int t);
    int n = 0;
    for (int i = 0; i < fs.size(); i++)
      if (fa[i] <= t && fs[i] > t) n++;
    return n;
  endfunction

  task automatic tick(input logic w, input logic [7:0] d, input logic r);
    int occ;
    int s;
    int b;
    int x_tx;
    int x_busy;
    logic [7:0] byt;
    rst_i  = r;
    wen_i  = w;
    data_i = d;
    @(posedge clk_i);
    e++;
    if (r) begin
      fa.delete(); fs.delete(); fd.delete();
      m_ovf = 0;
      have_last = 0;
    end else if (w) begin
      occ = occupancy(e - 1);
      if (occ >= DEPTH) m_ovf = 1;
      else begin
        s = e + 1;
        if (have_last && last_s + FRAME > s) s = last_s + FRAME;
        fa.push_back(e); fs.push_back(s); fd.push_back(d);
        last_s = s;
        have_last = 1;
      end
    end
    while (fs.size() > 0 && fs[0] + FRAME <= e) begin
      void'(fa.pop_front()); void'(fs.pop_front()); void'(fd.pop_front());
    end
    @(negedge clk_i);
    x_tx = 1;
    x_busy = 0;
    for (int i = 0; i < fs.size(); i++) begin
      if (fs[i] <= e && e < fs[i] + FRAME) begin
        b = (e - fs[i]) / CPB;
        byt = fd[i];
        x_busy = 1;
        if (b == 0)      x_tx = 0;
        else if (b == 9) x_tx = 1;
        else             x_tx = int'(byt[b-1]);
      end
    end
    occ = occupancy(e);
    check("tx",    int'(tx_o),       x_tx);
    check("busy",  int'(busy_o),     x_busy);
    check("count", int'(count_o),    occ);
    check("empty", int'(empty_o),    int'(occ == 0));
    check("full",  int'(full_o),     int'(occ == DEPTH));
    check("ovf",   int'(overflow_o), int'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (have_last && e < last_s + FRAME + 1 && guard < 2000) begin
      tick(1'b0, 8'h00, 1'b0);
      guard++;
    end
    check("drain_done", int'(busy_o), 0);
  endtask

  initial begin
    int s_ff;
    int s_b;
    int rate;

    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    check("rst_tx",    int'(tx_o),       1);
    check("rst_count", int'(count_o),    0);
    idle(3);

    tick(1'b1, 8'hA5, 1'b0);
    drain();
    idle(2);

    peak = 0;
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    if (int'(count_o) > peak) peak = int'(count_o);
    tick(1'b1, 8'h03, 1'b0);
    if (int'(count_o) > peak) peak = int'(count_o);
    for (int i = 0; i < 3 * FRAME + 4; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (int'(count_o) > peak) peak = int'(count_o);
    end
    check("b2b_peak", peak, 2);
    drain();
    idle(2);

    for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h10 + i), 1'b0);
    check("ovf_set", int'(overflow_o), 1);
    drain();
    idle(3);
    check("ovf_sticky", int'(overflow_o), 1);
    tick(1'b0, 8'h00, 1'b1);
    check("ovf_clr", int'(overflow_o), 0);
    idle(2);

    tick(1'b1, 8'h3C, 1'b0);
    idle(2);
    tick(1'b1, 8'hC3, 1'b0);
    s_b = last_s;
    while (e + 1 < s_b) tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h7E, 1'b0);
    check("simul_cnt", int'(count_o), 1);
    drain();
    idle(2);

    tick(1'b1, 8'hFF, 1'b0);
    s_ff = last_s;
    tick(1'b1, 8'h81, 1'b0);
    tick(1'b1, 8'h42, 1'b0);
    while (e < s_ff + 16) tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    check("midrst_tx",  int'(tx_o),    1);
    check("midrst_cnt", int'(count_o), 0);
    idle(2 * FRAME);
    check("midrst_busy", int'(busy_o), 0);

    for (int blk = 0; blk < 12; blk++) begin
      rate = $urandom_range(2, 60);
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 1999) == 0)
          tick(1'b0, 8'h00, 1'b1);
        else
          tick(($urandom_range(0, rate - 1) == 0), 8'($urandom), 1'b0);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
